// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and debug width.
package rst_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    FILTER  = 3'd1,
    HOLD    = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// N-stage synchronizer with asynchronous active-low clear.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: lock filtering, hold period and staggered per-domain reset release.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned N_DOM       = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               lock_i,
  input  logic               sw_rst_i,
  output logic [N_DOM-1:0]   rst_n_o,
  output logic               ready_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned STAG_W = $clog2(STAGGER + 1);
  localparam int unsigned DOM_W  = $clog2(N_DOM + 1);
  localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
  localparam logic [DOM_W-1:0]  DOM_END   = DOM_W'(N_DOM);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER);

  logic rst_int_n;
  logic lock_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk   (clk_i),
    .clr_n (rst_n_i),
    .d     (1'b1),
    .q     (rst_int_n)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk_i),
    .clr_n (rst_int_n),
    .d     (lock_i),
    .q     (lock_s)
  );

  state_e             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [STAG_W-1:0]  stag_cnt, stag_nxt;
  logic [DOM_W-1:0]   dom_idx, idx_nxt;
  logic [FILT_W-1:0]  filt_cnt, filt_nxt;
  logic [N_DOM-1:0]   rst_q, rst_nxt;
  logic               ready_q, ready_nxt;

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      stag_cnt <= '0;
      dom_idx  <= '0;
      filt_cnt <= '0;
      rst_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      stag_cnt <= stag_nxt;
      dom_idx  <= idx_nxt;
      filt_cnt <= filt_nxt;
      rst_q    <= rst_nxt;
      ready_q  <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    stag_nxt  = stag_cnt;
    idx_nxt   = dom_idx;
    filt_nxt  = filt_cnt;
    rst_nxt   = rst_q;
    ready_nxt = ready_q;

    case (state)
      IDLE: begin
        if (lock_s) begin
          state_nxt = FILTER;
          filt_nxt  = FILT_W'(1);
        end
      end
      FILTER: begin
        if (!lock_s) begin
          state_nxt = IDLE;
          filt_nxt  = '0;
        end else if (filt_cnt == FILT_LAST) begin
          state_nxt = HOLD;
          filt_nxt  = '0;
          hold_nxt  = '0;
        end else begin
          filt_nxt = filt_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt  = RELEASE;
          rst_nxt[0] = 1'b1;
          idx_nxt    = DOM_W'(1);
          stag_nxt   = '0;
          hold_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (dom_idx == DOM_END) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end else if (stag_cnt == STAG_LAST) begin
          // dom_idx is compared per bit so it is never used as an out-of-range index
          for (int unsigned k = 0; k < N_DOM; k++) begin
            if (DOM_W'(k) == dom_idx) rst_nxt[k] = 1'b1;
          end
          idx_nxt  = dom_idx + 1'b1;
          stag_nxt = '0;
        end else begin
          stag_nxt = stag_cnt + 1'b1;
        end
      end
      RUN: ;
      default: state_nxt = IDLE;
    endcase

    // Lock loss overrides a simultaneous software request.
    if ((state inside {HOLD, RELEASE, RUN}) && (!lock_s || sw_rst_i)) begin
      state_nxt = lock_s ? HOLD : IDLE;
      hold_nxt  = '0;
      stag_nxt  = '0;
      idx_nxt   = '0;
      filt_nxt  = '0;
      rst_nxt   = '0;
      ready_nxt = 1'b0;
    end
  end

  assign rst_n_o = rst_q;
  assign ready_o = ready_q;
  assign state_o = state;

endmodule
